// File: rtl/user_input_conditioner_pkg.sv
// Shared definitions for the user input conditioner: debounce FSM encoding
// and the default timing constants.
package user_input_conditioner_pkg;

    typedef enum logic [1:0] {
        STABLE_HI = 2'd0,
        CHK_LO    = 2'd1,
        STABLE_LO = 2'd2,
        CHK_HI    = 2'd3
    } debounce_state_e;

    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int REPEAT_DELAY_DEF    = 16;
    localparam int REPEAT_PERIOD_DEF   = 4;

endpackage

// File: rtl/user_input_conditioner_sync2.sv
// Two-flop synchronizer for an asynchronous pin; both flops reset to RESET_VAL
// so an idle pin produces no spurious edge on reset release.
module user_input_conditioner_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q <= RESET_VAL;
            s2_q <= RESET_VAL;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/user_input_conditioner.sv
// Synchronizes, debounces and optionally auto-repeats an idle-high user input,
// producing single-cycle fall/rise event pulses.
module user_input_conditioner
    import user_input_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF,
    parameter int unsigned CNT_W           = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    input  logic repeat_en,
    output logic level,
    output logic fall_pulse,
    output logic rise_pulse
);

    localparam logic [CNT_W-1:0] DEB_LIM = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] DLY_LIM = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] PER_LIM = CNT_W'(REPEAT_PERIOD);

    logic             syncIn;
    logic             mismatch;
    debounce_state_e  state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] rpt_q;
    logic [CNT_W-1:0] rpt_d;
    logic [CNT_W-1:0] rptLimit;
    logic             rptPhase_q;
    logic             level_q;
    logic             fallPulse_q;
    logic             risePulse_q;

    user_input_conditioner_sync2 #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d_i(in),
        .q_o(syncIn)
    );

    // rptPhase_q selects the first-repeat delay versus the steady repeat period.
    assign mismatch = (syncIn != level_q);
    assign cnt_d    = cnt_q + CNT_W'(1);
    assign rpt_d    = rpt_q + CNT_W'(1);
    assign rptLimit = rptPhase_q ? PER_LIM : DLY_LIM;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= STABLE_HI;
            cnt_q       <= '0;
            rpt_q       <= '0;
            rptPhase_q  <= 1'b0;
            level_q     <= 1'b1;
            fallPulse_q <= 1'b0;
            risePulse_q <= 1'b0;
        end else begin
            fallPulse_q <= 1'b0;
            risePulse_q <= 1'b0;
            case (state_q)
                STABLE_HI: begin
                    if (mismatch) begin
                        if (DEB_LIM == CNT_W'(1)) begin
                            state_q     <= STABLE_LO;
                            level_q     <= 1'b0;
                            fallPulse_q <= 1'b1;
                            cnt_q       <= '0;
                            rpt_q       <= '0;
                            rptPhase_q  <= 1'b0;
                        end else begin
                            state_q <= CHK_LO;
                            cnt_q   <= CNT_W'(1);
                        end
                    end
                end
                CHK_LO: begin
                    if (!mismatch) begin
                        state_q <= STABLE_HI;
                        cnt_q   <= '0;
                    end else if (cnt_d == DEB_LIM) begin
                        state_q     <= STABLE_LO;
                        level_q     <= 1'b0;
                        fallPulse_q <= 1'b1;
                        cnt_q       <= '0;
                        rpt_q       <= '0;
                        rptPhase_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                STABLE_LO: begin
                    if (!repeat_en) begin
                        rpt_q      <= '0;
                        rptPhase_q <= 1'b0;
                    end else if (rpt_d == rptLimit) begin
                        fallPulse_q <= 1'b1;
                        rpt_q       <= '0;
                        rptPhase_q  <= 1'b1;
                    end else begin
                        rpt_q <= rpt_d;
                    end
                    // An immediate high acceptance overrides any repeat fired this cycle.
                    if (mismatch) begin
                        if (DEB_LIM == CNT_W'(1)) begin
                            state_q     <= STABLE_HI;
                            level_q     <= 1'b1;
                            risePulse_q <= 1'b1;
                            fallPulse_q <= 1'b0;
                            cnt_q       <= '0;
                            rpt_q       <= '0;
                            rptPhase_q  <= 1'b0;
                        end else begin
                            state_q <= CHK_HI;
                            cnt_q   <= CNT_W'(1);
                        end
                    end
                end
                CHK_HI: begin
                    if (!mismatch) begin
                        state_q <= STABLE_LO;
                        cnt_q   <= '0;
                    end else if (cnt_d == DEB_LIM) begin
                        state_q     <= STABLE_HI;
                        level_q     <= 1'b1;
                        risePulse_q <= 1'b1;
                        cnt_q       <= '0;
                        rpt_q       <= '0;
                        rptPhase_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    state_q <= STABLE_HI;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign level      = level_q;
    assign fall_pulse = fallPulse_q;
    assign rise_pulse = risePulse_q;

endmodule

// File: tb/tb_user_input_conditioner.sv
// Self-checking bench for user_input_conditioner: directed timing scenarios plus
// randomized input runs compared against a behavioural reference model.
module tb_user_input_conditioner;
    import user_input_conditioner_pkg::*;

    localparam int D  = DEBOUNCE_CYCLES_DEF;
    localparam int RD = REPEAT_DELAY_DEF;
    localparam int RP = REPEAT_PERIOD_DEF;

    logic clk = 1'b0;
    logic rst;
    logic in;
    logic repeatEn;
    logic level;
    logic fallPulse;
    logic risePulse;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: sync pipe, accepted level, run of mismatching
    // samples, and cycles held low while repeating with the next firing count.
    logic mS1, mS2, mLevel, mFall, mRise;
    int   mMism, mRptCount, mNextFire;

    user_input_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in(in),
        .repeat_en(repeatEn),
        .level(level),
        .fall_pulse(fallPulse),
        .rise_pulse(risePulse)
    );

    always #5 clk = ~clk;

    task automatic modelReset();
        mS1 = 1'b1; mS2 = 1'b1; mLevel = 1'b1; mFall = 1'b0; mRise = 1'b0;
        mMism = 0; mRptCount = 0; mNextFire = RD;
    endtask

    task automatic modelEdge(input logic inV, input logic repV);
        mFall = 1'b0;
        mRise = 1'b0;
        if (mLevel == 1'b0 && mMism == 0) begin
            if (!repV) begin
                mRptCount = 0;
                mNextFire = RD;
            end else begin
                mRptCount++;
                if (mRptCount == mNextFire) begin
                    mFall = 1'b1;
                    mNextFire += RP;
                end
            end
        end
        if (mS2 != mLevel) begin
            mMism++;
            if (mMism == D) begin
                mLevel    = mS2;
                mMism     = 0;
                mRptCount = 0;
                mNextFire = RD;
                mFall     = ~mLevel;
                mRise     = mLevel;
            end
        end else begin
            mMism = 0;
        end
        mS2 = mS1;
        mS1 = inV;
    endtask

    // Drive one cycle of inputs, advance the model at the edge, land 1ns after it.
    task automatic applyStimulus(input logic inV, input logic repV);
        in       = inV;
        repeatEn = repV;
        @(posedge clk);
        modelEdge(inV, repV);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; in = 1'b1; repeatEn = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({level, fallPulse, risePulse} !== 3'b100) begin
            miscompares++;
            $display("[TB] FAIL reset_active: got %b, expected %b", {level, fallPulse, risePulse}, 3'b100);
        end
        rst = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            applyStimulus(1'b1, 1'b0);
            vectors++;
            if ({level, fallPulse, risePulse} !== 3'b100) begin
                miscompares++;
                $display("[TB] FAIL reset_hold cycle %0d: got %b, expected %b", i, {level, fallPulse, risePulse}, 3'b100);
            end
        end
    endtask

    task automatic test_clean_press();
        logic [2:0] exp;
        for (int i = 1; i <= 12; i++) begin
            applyStimulus(1'b0, 1'b0);
            exp = {(i < D + 2), (i == D + 2), 1'b0};
            vectors++;
            if ({level, fallPulse, risePulse} !== exp) begin
                miscompares++;
                $display("[TB] FAIL clean_press edge %0d: got %b, expected %b", i, {level, fallPulse, risePulse}, exp);
            end
        end
    endtask

    task automatic test_release();
        logic [2:0] exp;
        for (int i = 1; i <= 12; i++) begin
            applyStimulus(1'b1, 1'b0);
            exp = {(i >= D + 2), 1'b0, (i == D + 2)};
            vectors++;
            if ({level, fallPulse, risePulse} !== exp) begin
                miscompares++;
                $display("[TB] FAIL release edge %0d: got %b, expected %b", i, {level, fallPulse, risePulse}, exp);
            end
        end
    endtask

    task automatic test_bounce();
        logic pattern [16];
        for (int i = 0; i < 16; i++) pattern[i] = 1'b1;
        pattern[0] = 1'b0; pattern[1] = 1'b0; pattern[2] = 1'b0;
        pattern[4] = 1'b0; pattern[5] = 1'b0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(pattern[i], 1'b0);
            vectors++;
            if ({level, fallPulse, risePulse} !== 3'b100) begin
                miscompares++;
                $display("[TB] FAIL bounce cycle %0d: got %b, expected %b", i, {level, fallPulse, risePulse}, 3'b100);
            end
        end
    endtask

    task automatic test_repeat();
        logic [2:0] exp;
        int j;
        for (int i = 1; i <= D + 2 + 40; i++) begin
            applyStimulus(1'b0, 1'b1);
            j = i - (D + 2);
            exp = {(i < D + 2), (j == 0) || (j >= RD && ((j - RD) % RP) == 0), 1'b0};
            vectors++;
            if ({level, fallPulse, risePulse} !== exp) begin
                miscompares++;
                $display("[TB] FAIL repeat offset %0d: got %b, expected %b", j, {level, fallPulse, risePulse}, exp);
            end
        end
        // Drop repeat_en exactly on the edge that would fire (offset 44), then re-arm.
        for (int k = 41; k <= 61; k++) begin
            applyStimulus(1'b0, (k != 44));
            exp = {1'b0, (k == 44 + RD), 1'b0};
            vectors++;
            if ({level, fallPulse, risePulse} !== exp) begin
                miscompares++;
                $display("[TB] FAIL repeat_disable offset %0d: got %b, expected %b", k, {level, fallPulse, risePulse}, exp);
            end
        end
        for (int i = 1; i <= 12; i++) begin
            applyStimulus(1'b1, 1'b0);
            exp = {(i >= D + 2), 1'b0, (i == D + 2)};
            vectors++;
            if ({level, fallPulse, risePulse} !== exp) begin
                miscompares++;
                $display("[TB] FAIL repeat_release edge %0d: got %b, expected %b", i, {level, fallPulse, risePulse}, exp);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [2:0] exp;
        for (int i = 1; i <= 3; i++) applyStimulus(1'b0, 1'b0);
        #3 rst = 1'b0;
        #1;
        vectors++;
        if ({level, fallPulse, risePulse} !== 3'b100) begin
            miscompares++;
            $display("[TB] FAIL reset_in_chk_lo: got %b, expected %b", {level, fallPulse, risePulse}, 3'b100);
        end
        modelReset();
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 1; i <= D + 2 + 20; i++) begin
            applyStimulus(1'b0, 1'b1);
            exp = {(i < D + 2), (i == D + 2) || (i == D + 2 + RD) || (i == D + 2 + RD + RP), 1'b0};
            vectors++;
            if ({level, fallPulse, risePulse} !== exp) begin
                miscompares++;
                $display("[TB] FAIL press_after_reset edge %0d: got %b, expected %b", i, {level, fallPulse, risePulse}, exp);
            end
        end
        // A repeat pulse is high right now; reset must clear it and raise level at once.
        #3 rst = 1'b0;
        #1;
        vectors++;
        if ({level, fallPulse, risePulse} !== 3'b100) begin
            miscompares++;
            $display("[TB] FAIL reset_in_repeat: got %b, expected %b", {level, fallPulse, risePulse}, 3'b100);
        end
        modelReset();
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b0, 1'b1);
            exp = {(i < D + 2), (i == D + 2), 1'b0};
            vectors++;
            if ({level, fallPulse, risePulse} !== exp) begin
                miscompares++;
                $display("[TB] FAIL repress_after_reset edge %0d: got %b, expected %b", i, {level, fallPulse, risePulse}, exp);
            end
        end
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(1'b1, 1'b0);
            vectors++;
            if ({level, fallPulse, risePulse} !== {mLevel, mFall, mRise}) begin
                miscompares++;
                $display("[TB] FAIL mid_reset_release edge %0d: got %b, expected %b", i, {level, fallPulse, risePulse}, {mLevel, mFall, mRise});
            end
        end
    endtask

    task automatic test_random();
        int   runLeft = 0;
        logic val = 1'b1;
        logic rep = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            if (runLeft == 0) begin
                val = ~val;
                runLeft = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : int'($urandom_range(5, 40));
            end
            runLeft--;
            if ($urandom_range(0, 15) == 0) rep = ~rep;
            if ($urandom_range(0, 399) == 0) begin
                #3 rst = 1'b0;
                #1;
                vectors++;
                if ({level, fallPulse, risePulse} !== 3'b100) begin
                    miscompares++;
                    $display("[TB] FAIL random_reset cycle %0d: got %b, expected %b", c, {level, fallPulse, risePulse}, 3'b100);
                end
                modelReset();
                @(posedge clk);
                #1 rst = 1'b1;
            end
            applyStimulus(val, rep);
            vectors++;
            if ({level, fallPulse, risePulse} !== {mLevel, mFall, mRise}) begin
                miscompares++;
                $display("[TB] FAIL random cycle %0d in=%b rep=%b: got %b, expected %b", c, val, rep, {level, fallPulse, risePulse}, {mLevel, mFall, mRise});
            end
        end
    endtask

    initial begin
        rst      = 1'b0;
        in       = 1'b1;
        repeatEn = 1'b0;
        test_reset();
        test_clean_press();
        test_release();
        test_bounce();
        test_repeat();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
